// File: rtl/tft_capture_if.sv
// Panel-bus receive interface: RGB888 bus in, tagged pixel stream and
// timing measurements out. The capture block is the slave side.
interface tft_capture_if;
   logic [7:0]  red_in, green_in, blue_in;
   logic        hsync, vsync, data_en;
   logic [7:0]  red_out, green_out, blue_out;
   logic        pixel_valid;
   logic [15:0] vis_x_pos, vis_y_pos;
   logic        sof, eol, frame_done;
   logic [15:0] meas_resx, meas_resy, meas_h_total, meas_v_total;
   logic        locked;

   modport slave (
      input  red_in, green_in, blue_in, hsync, vsync, data_en,
      output red_out, green_out, blue_out, pixel_valid, vis_x_pos, vis_y_pos,
             sof, eol, frame_done, meas_resx, meas_resy, meas_h_total,
             meas_v_total, locked
   );

   modport master (
      output red_in, green_in, blue_in, hsync, vsync, data_en,
      input  red_out, green_out, blue_out, pixel_valid, vis_x_pos, vis_y_pos,
             sof, eol, frame_done, meas_resx, meas_resy, meas_h_total,
             meas_v_total, locked
   );
endinterface

// File: rtl/tft_capture.sv
// TFT panel-bus receiver: registers the bus, tags visible pixels with x/y
// and frame/line markers, and measures per-frame timing with lock detect.
// Pipeline: s1 (bus sample) -> p (tagged pixel / frame close) -> outputs.
module tft_capture (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture_en,
   tft_capture_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t      state, state_nxt;
   logic        s1_hs, s1_vs, s1_de, s0_hs, s0_vs;
   logic [23:0] s1_rgb;
   logic        hs_fall, vs_fall, in_cap, enter_cap, close_frame;

   logic [15:0] hclk, hlines, x_cnt, act_lines, last_resx, last_htot;
   logic        line_had;
   logic [15:0] act_closed, resx_closed, htot_closed, hlines_closed;
   logic [15:0] px_x, px_y;

   logic        p_vld, p_sof, p_eol, p_fd;
   logic [23:0] p_rgb;
   logic [15:0] p_x, p_y, p_resx, p_resy, p_htot, p_vtot;

   logic        o_vld, o_sof, o_eol, o_fd, o_lock;
   logic [23:0] o_rgb;
   logic [15:0] o_x, o_y, o_resx, o_resy, o_htot, o_vtot;

   // bus sample (s1) plus previous sample (s0) for sync edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0; s1_rgb <= 24'd0;
         s0_hs <= 1'b0; s0_vs <= 1'b0;
      end else begin
         s1_hs  <= bus.hsync;
         s1_vs  <= bus.vsync;
         s1_de  <= bus.data_en;
         s1_rgb <= {bus.red_in, bus.green_in, bus.blue_in};
         s0_hs  <= s1_hs;
         s0_vs  <= s1_vs;
      end
   end

   assign hs_fall = s0_hs & ~s1_hs;
   assign vs_fall = s0_vs & ~s1_vs;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state: dropping capture_en aborts from anywhere
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (capture_en) state_nxt = WAIT_VS;
         WAIT_VS: if (!capture_en) state_nxt = IDLE;
                  else if (vs_fall) state_nxt = CAPTURE;
         CAPTURE: if (!capture_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM-derived controls for the counters and pixel stage
   always_comb begin
      in_cap      = (state == CAPTURE) && capture_en;
      enter_cap   = (state == WAIT_VS) && capture_en && vs_fall;
      close_frame = in_cap && vs_fall;
   end

   // line closure values; a coincident hs_fall is folded in before a frame latch
   always_comb begin
      line_had      = (x_cnt != 16'd0);
      act_closed    = line_had ? sat_inc(act_lines) : act_lines;
      resx_closed   = (hs_fall && line_had) ? x_cnt : last_resx;
      htot_closed   = hs_fall ? hclk : last_htot;
      hlines_closed = hs_fall ? sat_inc(hlines) : hlines;
      px_x          = (hs_fall || vs_fall) ? 16'd0 : x_cnt;
      px_y          = vs_fall ? 16'd0 : (hs_fall ? act_closed : act_lines);
   end

   // per-frame timing counters, all saturating
   always_ff @(posedge clk) begin
      if (rst || !(in_cap || enter_cap)) begin
         hclk <= 16'd0; hlines <= 16'd0; x_cnt <= 16'd0;
         act_lines <= 16'd0; last_resx <= 16'd0; last_htot <= 16'd0;
      end else if (vs_fall) begin
         hclk      <= hs_fall ? 16'd1 : 16'd0;
         hlines    <= 16'd0;
         x_cnt     <= (close_frame && s1_de) ? 16'd1 : 16'd0;
         act_lines <= 16'd0;
         last_resx <= 16'd0;
         last_htot <= 16'd0;
      end else if (hs_fall) begin
         hclk      <= 16'd1;
         hlines    <= hlines_closed;
         act_lines <= act_closed;
         last_resx <= resx_closed;
         last_htot <= hclk;
         x_cnt     <= {15'd0, s1_de};
      end else begin
         hclk <= sat_inc(hclk);
         if (s1_de) x_cnt <= sat_inc(x_cnt);
      end
   end

   // tagged pixel / frame-close stage; eol looks ahead at the live data_en
   always_ff @(posedge clk) begin
      if (rst || !capture_en) begin
         p_vld <= 1'b0; p_sof <= 1'b0; p_eol <= 1'b0; p_fd <= 1'b0;
         p_rgb <= 24'd0; p_x <= 16'd0; p_y <= 16'd0;
         p_resx <= 16'd0; p_resy <= 16'd0; p_htot <= 16'd0; p_vtot <= 16'd0;
      end else begin
         p_vld <= in_cap && s1_de;
         p_sof <= in_cap && s1_de && (px_x == 16'd0) && (px_y == 16'd0);
         p_eol <= in_cap && s1_de && !bus.data_en;
         p_rgb <= s1_rgb;
         p_x   <= px_x;
         p_y   <= px_y;
         p_fd  <= close_frame;
         if (close_frame) begin
            p_resx <= resx_closed;
            p_resy <= act_closed;
            p_htot <= htot_closed;
            p_vtot <= hlines_closed;
         end
      end
   end

   // output stage; measurements and lock only change on a frame close
   always_ff @(posedge clk) begin
      if (rst) begin
         o_vld <= 1'b0; o_sof <= 1'b0; o_eol <= 1'b0; o_fd <= 1'b0;
         o_rgb <= 24'd0; o_x <= 16'd0; o_y <= 16'd0; o_lock <= 1'b0;
         o_resx <= 16'd0; o_resy <= 16'd0; o_htot <= 16'd0; o_vtot <= 16'd0;
      end else if (!capture_en) begin
         o_vld <= 1'b0; o_sof <= 1'b0; o_eol <= 1'b0; o_fd <= 1'b0;
      end else begin
         o_vld <= p_vld;
         o_sof <= p_sof;
         o_eol <= p_eol;
         o_fd  <= p_fd;
         o_rgb <= p_rgb;
         o_x   <= p_x;
         o_y   <= p_y;
         if (p_fd) begin
            o_resx <= p_resx;
            o_resy <= p_resy;
            o_htot <= p_htot;
            o_vtot <= p_vtot;
            o_lock <= (p_resx == o_resx) && (p_resy == o_resy) &&
                      (p_htot == o_htot) && (p_vtot == o_vtot) &&
                      (p_resx != 16'd0) && (p_resy != 16'd0) &&
                      (p_htot != 16'd0) && (p_vtot != 16'd0);
         end
      end
   end

   assign bus.red_out      = o_rgb[23:16];
   assign bus.green_out    = o_rgb[15:8];
   assign bus.blue_out     = o_rgb[7:0];
   assign bus.pixel_valid  = o_vld;
   assign bus.vis_x_pos    = o_x;
   assign bus.vis_y_pos    = o_y;
   assign bus.sof          = o_sof;
   assign bus.eol          = o_eol;
   assign bus.frame_done   = o_fd;
   assign bus.meas_resx    = o_resx;
   assign bus.meas_resy    = o_resy;
   assign bus.meas_h_total = o_htot;
   assign bus.meas_v_total = o_vtot;
   assign bus.locked       = o_lock;
endmodule

// File: tb/tb_tft_capture.sv
// Bench for tft_capture: frame generator driving random pixel data, with a
// frame-level model predicting every pixel (value, coordinates, markers,
// arrival cycle) and every frame_done measurement set.
module tb_tft_capture;
   typedef struct packed {
      logic [23:0] rgb;
      logic [15:0] x, y;
      logic        sof, eol;
      logic [31:0] cyc;
   } pix_t;

   typedef struct packed {
      logic [15:0] resx, resy, htot, vtot;
      logic        lk;
      logic [31:0] cyc;
   } meas_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic capture_en = 1'b0;

   tft_capture_if bus();
   tft_capture dut (.clk(clk), .rst(rst), .capture_en(capture_en), .bus(bus));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // model state
   pix_t        pq[$];
   meas_t       mq[$];
   bit          cap_active = 0, have_open = 0, pix_mode = 0;
   int          quiet_from = 32'h7fffffff;
   logic [15:0] o_resx, o_resy, o_htot, o_vtot;
   logic [15:0] l_resx = 0, l_resy = 0, l_htot = 0, l_vtot = 0;
   logic        l_lk = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_vld"}, bus.pixel_valid, 0);
      chk({t, "_sof"}, bus.sof, 0);
      chk({t, "_eol"}, bus.eol, 0);
      chk({t, "_fd"}, bus.frame_done, 0);
      chk({t, "_lock"}, bus.locked, 0);
      chk({t, "_resx"}, bus.meas_resx, 0);
      chk({t, "_resy"}, bus.meas_resy, 0);
      chk({t, "_htot"}, bus.meas_h_total, 0);
      chk({t, "_vtot"}, bus.meas_v_total, 0);
      chk({t, "_xy"}, {bus.vis_x_pos, bus.vis_y_pos}, 0);
      chk({t, "_rgb"}, {bus.red_out, bus.green_out, bus.blue_out}, 0);
   endtask

   // a vsync fall closes the open frame (if any) and opens a new one when enabled
   task automatic frame_start(input logic [15:0] rx, ry, ht, vt);
      meas_t m;
      if (have_open) begin
         m.resx = o_resx; m.resy = o_resy; m.htot = o_htot; m.vtot = o_vtot;
         m.lk = (o_resx == l_resx) && (o_resy == l_resy) && (o_htot == l_htot) &&
                (o_vtot == l_vtot) && (o_resx != 0) && (o_resy != 0) &&
                (o_htot != 0) && (o_vtot != 0);
         m.cyc = cyc + 3;
         mq.push_back(m);
         l_resx = o_resx; l_resy = o_resy; l_htot = o_htot; l_vtot = o_vtot;
         l_lk = m.lk;
      end
      cap_active = capture_en;
      have_open  = capture_en;
      o_resx = rx; o_resy = ry; o_htot = ht; o_vtot = vt;
      pix_mode   = 0;
      quiet_from = 32'h7fffffff;
   endtask

   task automatic push_pix(input logic [23:0] rgb, input int x, input int y, input bit sof, input bit eol);
      pix_t e;
      e.rgb = rgb; e.x = 16'(x); e.y = 16'(y); e.sof = sof; e.eol = eol;
      e.cyc = cyc + 3;
      pq.push_back(e);
   endtask

   // one frame: h 4/4/resx/4, v 2/2/8/2; optional capture drop/raise or reset
   task automatic run_frame(input int resx, input int drop_at, input int raise_at, input int rst_at);
      int ht = 12 + resx;
      int c = 0;
      logic [23:0] rgb;
      bit vis;
      frame_start(16'(resx), 16'd8, 16'(ht), 16'd14);
      pix_mode = (drop_at >= 0) || (rst_at >= 0);
      for (int ln = 0; ln < 14; ln++) begin
         for (int h = 0; h < ht; h++) begin
            if (c == drop_at) begin
               capture_en = 1'b0; cap_active = 0; have_open = 0; quiet_from = cyc + 2;
            end
            if (c == raise_at) capture_en = 1'b1;
            if (c == rst_at) begin
               rst = 1'b1; cap_active = 0; have_open = 0; quiet_from = cyc + 1;
               l_resx = 0; l_resy = 0; l_htot = 0; l_vtot = 0; l_lk = 0;
            end
            vis = (ln >= 4) && (ln < 12) && (h >= 8) && (h < 8 + resx);
            rgb = 24'($urandom);
            bus.hsync = (h < 4) ? 1'b0 : 1'b1;
            bus.vsync = (ln < 2) ? 1'b0 : 1'b1;
            bus.data_en = vis;
            {bus.red_in, bus.green_in, bus.blue_in} = rgb;
            if (vis && cap_active && !pix_mode)
               push_pix(rgb, h - 8, ln - 4, (h == 8) && (ln == 4), h == 7 + resx);
            tick;
            if (c == rst_at) begin
               chk_zero("midrst");
               rst = 1'b0;
            end
            c++;
         end
      end
      if (drop_at >= 0) begin
         chk("hold_resx", bus.meas_resx, l_resx);
         chk("hold_resy", bus.meas_resy, l_resy);
         chk("hold_htot", bus.meas_h_total, l_htot);
         chk("hold_vtot", bus.meas_v_total, l_vtot);
         chk("hold_lock", bus.locked, l_lk);
      end
   endtask

   // one line with data_en held for 70000 clocks, opened by a coincident hs/vs fall
   task automatic run_sat;
      logic [23:0] rgb;
      frame_start(16'hFFFF, 16'd1, 16'hFFFF, 16'd1);
      for (int c = 0; c < 70010; c++) begin
         rgb = 24'($urandom);
         bus.hsync = (c < 4) ? 1'b0 : 1'b1;
         bus.vsync = (c < 4) ? 1'b0 : 1'b1;
         bus.data_en = (c >= 6) && (c < 70006);
         {bus.red_in, bus.green_in, bus.blue_in} = rgb;
         if (bus.data_en)
            push_pix(rgb, (c - 6 > 65535) ? 65535 : c - 6, 0, c == 6, c == 70005);
         tick;
      end
   endtask

   // scoreboard: pixels and frame_done against the model queues
   pix_t  g_pix, e_pix;
   meas_t g_m, e_m;
   always @(negedge clk) begin
      if (pix_mode) begin
         if (cyc >= quiet_from) begin
            checks++;
            assert (bus.pixel_valid === 1'b0) else begin
               errors++;
               $error("FAIL quiet_pix got=%0b exp=0 cyc=%0d", bus.pixel_valid, cyc);
            end
         end
      end else if (bus.pixel_valid === 1'b1) begin
         checks++;
         assert (pq.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_pix got x=%0d y=%0d exp none cyc=%0d",
                   bus.vis_x_pos, bus.vis_y_pos, cyc);
         end
         if (pq.size() != 0) begin
            e_pix = pq.pop_front();
            g_pix.rgb = {bus.red_out, bus.green_out, bus.blue_out};
            g_pix.x = bus.vis_x_pos; g_pix.y = bus.vis_y_pos;
            g_pix.sof = bus.sof; g_pix.eol = bus.eol;
            g_pix.cyc = cyc;
            assert (g_pix === e_pix) else begin
               errors++;
               $error("FAIL pixel got=%h exp=%h", g_pix, e_pix);
            end
         end
      end
      if (bus.frame_done === 1'b1) begin
         checks++;
         assert (mq.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_frame_done got=1 exp=0 cyc=%0d", cyc);
         end
         if (mq.size() != 0) begin
            e_m = mq.pop_front();
            g_m.resx = bus.meas_resx; g_m.resy = bus.meas_resy;
            g_m.htot = bus.meas_h_total; g_m.vtot = bus.meas_v_total;
            g_m.lk = bus.locked; g_m.cyc = cyc;
            assert (g_m === e_m) else begin
               errors++;
               $error("FAIL meas got=%h exp=%h", g_m, e_m);
            end
         end
      end
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.hsync = 1'b1; bus.vsync = 1'b1; bus.data_en = 1'b0;
      bus.red_in = 8'd0; bus.green_in = 8'd0; bus.blue_in = 8'd0;
      rst = 1'b1;
      repeat (3) tick;
      chk_zero("reset");
      rst = 1'b0;
      tick;
      capture_en = 1'b1;
      repeat (10) tick;

      // nominal 16x8: lock after the second measured frame
      repeat (4) run_frame(16, -1, -1, -1);
      // width change 16 -> 12: lock drops then recovers
      repeat (3) run_frame(12, -1, -1, -1);
      // capture dropped mid-line, re-raised mid-frame, reacquire at next vsync
      run_frame(16, 6 * 28 + 12, -1, -1);
      run_frame(16, -1, 5 * 28, -1);
      repeat (2) run_frame(16, -1, -1, -1);
      // one-cycle reset mid-frame, then reacquire
      run_frame(16, -1, -1, 7 * 28 + 10);
      repeat (3) run_frame(16, -1, -1, -1);
      // x/h counters saturate, closed by a coincident hs/vs fall
      run_sat;
      run_frame(16, -1, -1, -1);

      bus.hsync = 1'b1; bus.vsync = 1'b1; bus.data_en = 1'b0;
      repeat (10) tick;
      chk("pix_queue_drained", pq.size(), 0);
      chk("meas_queue_drained", mq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
